alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: accepts one instruction at a time,
// drives the ALU operands for one cycle, then writes the result and flags back to an 8x16 register file.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  ALUop,
    output logic        carryin,
    input  logic [15:0] ALUresult,
    input  logic        zero,
    input  logic        overflow,
    input  logic        carryout,
    input  logic        sign,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    localparam logic [2:0] OP_NEG     = 3'b101;
    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_LOADI   = 3'b111;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_regs [8];
    logic [15:0] r_instr;
    logic [15:0] r_res;
    logic [3:0]  r_cap_flags;
    logic [3:0]  r_flags;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_carryin;

    logic        w_accept;
    logic [2:0]  w_in_op;
    logic [2:0]  w_in_rs;
    logic [2:0]  w_in_rt;
    logic        w_in_alu;
    logic        w_in_two_src;
    logic [2:0]  w_op;
    logic [2:0]  w_rd;

    assign w_in_op      = instr[15:13];
    assign w_in_rs      = instr[9:7];
    assign w_in_rt      = instr[6:4];
    assign w_in_alu     = (w_in_op <= OP_NEG);
    assign w_in_two_src = (w_in_op < OP_NEG);
    assign w_accept     = instr_valid && (r_state == ST_IDLE);
    assign w_op         = r_instr[15:13];
    assign w_rd         = r_instr[12:10];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: w_next_state = ST_WB;
            ST_WB:    w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ALU drive registers: the register file cannot change between accept and ISSUE,
    // so operands are sampled at the accept edge and held for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_op  <= 3'd0;
            r_carryin <= 1'b0;
            r_instr   <= 16'd0;
        end else if (w_accept) begin
            r_instr   <= instr;
            r_alu_a   <= w_in_alu ? r_regs[w_in_rs] : 16'd0;
            r_alu_b   <= w_in_two_src ? r_regs[w_in_rt] : 16'd0;
            r_alu_op  <= w_in_alu ? w_in_op : 3'd0;
            r_carryin <= w_in_alu && instr[3] && r_flags[1];
        end else begin
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_op  <= 3'd0;
            r_carryin <= 1'b0;
        end
    end

    // Capture ALU response and produce completion pulses for the WB cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res       <= 16'd0;
            r_cap_flags <= 4'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_ready <= (w_next_state == ST_IDLE);
            if (r_state == ST_ISSUE) begin
                r_res       <= ALUresult;
                r_cap_flags <= {zero, overflow, carryout, sign};
                r_done      <= (w_op != OP_ILLEGAL);
                r_err       <= (w_op == OP_ILLEGAL);
            end else begin
                r_done      <= 1'b0;
                r_err       <= 1'b0;
            end
        end
    end

    // Register file and flag write-back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'd0;
            end
            r_flags <= 4'd0;
        end else if (r_state == ST_WB) begin
            case (w_op)
                OP_LOADI: r_regs[w_rd] <= {6'b000000, r_instr[9:0]};
                OP_ILLEGAL: begin
                    r_flags <= r_flags;
                end
                default: begin
                    r_regs[w_rd] <= r_res;
                    r_flags      <= r_cap_flags;
                end
            endcase
        end else begin
            r_flags <= r_flags;
        end
    end

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign ALUop       = r_alu_op;
    assign carryin     = r_carryin;
    assign flags       = r_flags;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_data    = r_regs[dbg_addr];

endmodule
